// File: rtl/coin_accumulator_pkg.sv
// coin_accumulator_pkg: FSM states and default denominations
// shared by the coin accumulator slice.
package coin_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    GAP      = 2'd2
  } state_t;

  localparam int unsigned COIN_HALF_1     = 2;
  localparam int unsigned COIN_HALF_10    = 20;
  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_MAX_BALANCE = 250;

endpackage

// File: rtl/coin_edge_detect.sv
// coin_edge_detect: one coin channel, optional 2-flop synchroniser
// (COIN_ACCUMULATOR_SYNC_EN) then a rising-edge event.
module coin_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic coin,
  output logic evt
);

  logic lvl;
  logic last;

`ifdef COIN_ACCUMULATOR_SYNC_EN
  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= coin;
      s2 <= s1;
    end
  end

  assign lvl = s2;
`else
  assign lvl = coin;
`endif

  always_ff @(posedge clk) begin
    if (rst) last <= 1'b0;
    else     last <= lvl;
  end

  assign evt = lvl & ~last;

endmodule

// File: rtl/coin_accumulator.sv
// coin_accumulator: N-channel coin credit, charge handshake and
// timed refund eject. Synchroniser enabled by COIN_ACCUMULATOR_SYNC_EN.
module coin_accumulator
  import coin_accumulator_pkg::*;
#(
  parameter int unsigned NUM_COINS = 2,
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter logic [NUM_COINS*WIDTH-1:0] COIN_VALUES =
    {8'(COIN_HALF_10), 8'(COIN_HALF_1)},
  parameter int unsigned MAX_BALANCE = DEF_MAX_BALANCE,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_COINS-1:0] coin_in,
  input  logic                 lock,
  input  logic                 charge_valid,
  input  logic [WIDTH-1:0]     charge_amt,
  output logic                 charge_ack,
  output logic                 charge_nak,
  input  logic                 refund_req,
  output logic [WIDTH-1:0]     balance,
  output logic                 coin_reject,
  output logic [NUM_COINS-1:0] disp_coin,
  output logic                 busy,
  output logic [WIDTH-1:0]     refund_lost
);

  localparam int unsigned CW =
    (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned NW = $clog2(NUM_COINS + 1);
  localparam logic [WIDTH:0] MAXB = (WIDTH+1)'(MAX_BALANCE);

  state_t               state;
  state_t               state_n;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_n;
  logic [WIDTH-1:0]     bal_n;
  logic [WIDTH-1:0]     lost_n;
  logic [WIDTH-1:0]     cval;
  logic [WIDTH-1:0]     dval;
  logic [NUM_COINS-1:0] ev;
  logic [NUM_COINS-1:0] fit_oh;
  logic [NUM_COINS-1:0] disp_n;
  logic [NW-1:0]        nev;
  logic                 fit;
  logic                 idle;
  logic                 credit;
  logic                 ack_n;
  logic                 nak_n;
  logic                 rej_n;

  for (genvar i = 0; i < NUM_COINS; i++) begin : g_ch
    coin_edge_detect u_det (
      .clk  (clk),
      .rst  (rst),
      .coin (coin_in[i]),
      .evt  (ev[i])
    );
  end

  // Ascending denominations: the last fitting channel is the largest.
  always_comb begin
    nev    = '0;
    cval   = '0;
    fit    = 1'b0;
    fit_oh = '0;
    dval   = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (ev[i]) begin
        nev  = nev + NW'(1);
        cval = COIN_VALUES[i*WIDTH +: WIDTH];
      end
      if (COIN_VALUES[i*WIDTH +: WIDTH] <= balance) begin
        fit    = 1'b1;
        fit_oh = NUM_COINS'(1) << i;
        dval   = COIN_VALUES[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bal_n   = balance;
    lost_n  = refund_lost;
    disp_n  = '0;
    ack_n   = 1'b0;
    nak_n   = 1'b0;
    rej_n   = 1'b0;
    idle    = (state == IDLE);
    credit  = idle && (nev == NW'(1)) && !lock &&
              ({1'b0, balance} + {1'b0, cval} <= MAXB);

    if (credit)          bal_n = balance + cval;
    else if (nev != '0)  rej_n = 1'b1;

    if (charge_valid) begin
      if (idle && charge_amt <= bal_n) begin
        bal_n = bal_n - charge_amt;
        ack_n = 1'b1;
      end else begin
        nak_n = 1'b1;
      end
    end

    unique case (state)
      IDLE: begin
        if (refund_req) state_n = DISPENSE;
      end
      DISPENSE: begin
        if (fit) begin
          disp_n  = fit_oh;
          bal_n   = balance - dval;
          cnt_n   = '0;
          state_n = GAP;
        end else begin
          lost_n  = balance;
          bal_n   = '0;
          state_n = IDLE;
        end
      end
      GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) state_n = DISPENSE;
        else cnt_n = cnt + CW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      balance     <= '0;
      refund_lost <= '0;
      disp_coin   <= '0;
      charge_ack  <= 1'b0;
      charge_nak  <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      balance     <= bal_n;
      refund_lost <= lost_n;
      disp_coin   <= disp_n;
      charge_ack  <= ack_n;
      charge_nak  <= nak_n;
      coin_reject <= rej_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_coin_accumulator.sv
// tb_coin_accumulator: directed plus random stimulus against a
// schedule-based reference model of credit, charge and refund.
module tb_coin_accumulator;

  localparam int NC   = 2;
  localparam int G    = 2;
  localparam int MAXB = 250;
`ifdef COIN_ACCUMULATOR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    int at;
    int coin;
  } pulse_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NC-1:0] coin_in = '0;
  logic          lock = 1'b0;
  logic          charge_valid = 1'b0;
  logic [7:0]    charge_amt = '0;
  logic          charge_ack;
  logic          charge_nak;
  logic          refund_req = 1'b0;
  logic [7:0]    balance;
  logic          coin_reject;
  logic [NC-1:0] disp_coin;
  logic          busy;
  logic [7:0]    refund_lost;

  int checks = 0;
  int errors = 0;

  int          val_tab [NC] = '{2, 20};
  int          m_bal, m_lost, m_end, now;
  bit          m_active;
  logic [NC-1:0] h [4];
  pulse_t      pq [$];
  int          e_ack, e_nak, e_rej, e_disp, e_busy;

  coin_accumulator dut (
    .clk          (clk),
    .rst          (rst),
    .coin_in      (coin_in),
    .lock         (lock),
    .charge_valid (charge_valid),
    .charge_amt   (charge_amt),
    .charge_ack   (charge_ack),
    .charge_nak   (charge_nak),
    .refund_req   (refund_req),
    .balance      (balance),
    .coin_reject  (coin_reject),
    .disp_coin    (disp_coin),
    .busy         (busy),
    .refund_lost  (refund_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d",
               tag, $time, obs, exp);
    end
  endtask

  // Predicts the effect of the coming clock edge from the driven inputs.
  task automatic model_edge();
    logic [NC-1:0] ev;
    int nev, v, rem, k, j;
    e_ack = 0; e_nak = 0; e_rej = 0; e_disp = 0;
    now++;
    if (rst) begin
      m_bal = 0; m_lost = 0; m_active = 0;
      pq.delete();
      for (int i = 0; i < 4; i++) h[i] = '0;
      e_busy = 0;
      return;
    end
    for (int i = 3; i > 0; i--) h[i] = h[i-1];
    h[0] = coin_in;
    ev = h[LAT] & ~h[LAT+1];
    nev = 0; v = 0;
    for (int i = 0; i < NC; i++)
      if (ev[i]) begin nev++; v = val_tab[i]; end
    if (nev > 0) begin
      if (!m_active && nev == 1 && !lock && m_bal + v <= MAXB)
        m_bal += v;
      else
        e_rej = 1;
    end
    if (charge_valid) begin
      if (!m_active && int'(charge_amt) <= m_bal) begin
        m_bal -= int'(charge_amt);
        e_ack = 1;
      end else begin
        e_nak = 1;
      end
    end
    if (m_active) begin
      if (pq.size() > 0 && pq[0].at == now) begin
        e_disp = 1 << pq[0].coin;
        m_bal -= val_tab[pq[0].coin];
        void'(pq.pop_front());
      end
      if (now == m_end) begin
        m_lost = m_bal; m_bal = 0; m_active = 0;
      end
    end else if (refund_req) begin
      m_active = 1;
      rem = m_bal; k = 0;
      while (1) begin
        j = -1;
        for (int i = 0; i < NC; i++)
          if (val_tab[i] <= rem &&
              (j < 0 || val_tab[i] > val_tab[j])) j = i;
        if (j < 0) break;
        pq.push_back('{now + 1 + k*(G+1), j});
        rem -= val_tab[j];
        k++;
      end
      m_end = now + 1 + k*(G+1);
    end
    e_busy = m_active;
  endtask

  task automatic step(input logic [NC-1:0] c, input logic lk,
                      input logic cv, input int amt,
                      input logic rr, input logic r);
    coin_in = c; lock = lk; charge_valid = cv;
    charge_amt = 8'(amt); refund_req = rr; rst = r;
    model_edge();
    @(negedge clk);
    chk("balance", balance, m_bal);
    chk("refund_lost", refund_lost, m_lost);
    chk("busy", busy, e_busy);
    chk("disp_coin", disp_coin, e_disp);
    chk("charge_ack", charge_ack, e_ack);
    chk("charge_nak", charge_nak, e_nak);
    chk("coin_reject", coin_reject, e_rej);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 0, 0, 0, 0, 0);
  endtask

  task automatic pulse(input int ch, input logic lk);
    step(NC'(1) << ch, lk, 0, 0, 0, 0);
    for (int i = 0; i <= LAT; i++) step('0, lk, 0, 0, 0, 0);
  endtask

  task automatic charge(input int amt);
    step('0, 0, 1, amt, 0, 0);
  endtask

  initial begin
    logic [NC-1:0] c;
    now = 0;
    for (int i = 0; i < 3; i++) step('0, 0, 0, 0, 0, 1);
    chk("reset_balance", balance, 0);

    for (int i = 0; i < 5; i++) step(2'b01, 0, 0, 0, 0, 0);
    idle(LAT + 2);
    chk("credit_once", balance, 2);

    step(2'b11, 0, 0, 0, 0, 0);
    idle(LAT + 2);
    pulse(0, 1);
    chk("reject_keeps", balance, 2);

    for (int i = 0; i < 11; i++) pulse(1, 0);
    for (int i = 0; i < 9; i++) pulse(0, 0);
    chk("bal_240", balance, 240);
    pulse(1, 0);
    chk("overflow_240", balance, 240);
    charge(10);
    pulse(1, 0);
    chk("reach_max", balance, 250);

    charge(228);
    chk("bal_22", balance, 22);
    charge(20);
    charge(5);
    chk("nak_keeps", balance, 2);
    for (int k = 0; k <= LAT; k++)
      step(k == 0 ? 2'b10 : 2'b00, 0, k == LAT, 21, 0, 0);
    idle(1);
    chk("credit_then_charge", balance, 1);

    pulse(1, 0); pulse(1, 0); pulse(0, 0);
    chk("bal_43", balance, 43);
    step('0, 0, 0, 0, 1, 0);
    pulse(0, 0);
    charge(5);
    idle(12);
    chk("lost_1", refund_lost, 1);
    chk("refund_empty", balance, 0);

    pulse(1, 0); pulse(1, 0);
    step('0, 0, 0, 0, 1, 0);
    idle(2);
    step('0, 0, 0, 0, 0, 1);
    chk("abort_bal", balance, 0);
    chk("abort_busy", busy, 0);
    chk("abort_lost", refund_lost, 0);
    chk("abort_disp", disp_coin, 0);

    c = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NC; i++)
        if ($urandom_range(0, 3) == 0) c[i] = ~c[i];
      step(c,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 5) == 0,
           ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 60),
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 499) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/coin_accumulator.md
# coin_accumulator

Parametrised multi-denomination coin accumulator for the vending datapath, replacing the fixed two-coin accumulator. It synchronises and edge-detects N coin sensor channels and credits a saturating balance. It serves purchase charges through a valid/ack/nak handshake and dispenses a refund as a timed sequence of coin-eject pulses. It sits between the coin sensor pins and the product-selection FSM.

## Interface
- NUM_COINS, 2: number of coin channels.
- WIDTH, 8: balance width in half-units.
- COIN_VALUES, {8'd20, 8'd2}: packed NUM_COINS*WIDTH vector; slice i is the value of channel i; values strictly ascending with index.
- MAX_BALANCE, 250: credit ceiling, must be < 2^WIDTH.
- GAP_CYCLES, 2: idle cycles between eject pulses, ≥1.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- coin_in  in  NUM_COINS  raw coin sensor levels.
- lock  in  1  inhibit crediting.
- charge_valid  in  1  charge request, single-cycle.
- charge_amt  in  WIDTH  amount to deduct.
- charge_ack  out  1  pulse: charge applied.
- charge_nak  out  1  pulse: charge refused.
- refund_req  in  1  request refund, sampled high.
- balance  out  WIDTH  current credit.
- coin_reject  out  1  pulse: a detected coin was not credited.
- disp_coin  out  NUM_COINS  one-hot eject pulse.
- busy  out  1  dispensing in progress.
- refund_lost  out  WIDTH  remainder of the last refund that could not be dispensed.

## Operation
- Per channel: optional 2-flop synchroniser, then rising-edge detect against a registered last value. Only a 0→1 transition is an event, and a held-high level never re-credits.
- Credit (IDLE only): exactly one event in the cycle, lock low, and balance+value ≤ MAX_BALANCE → balance += value.
- Credit rejection: any other event cycle (≥2 simultaneous events, lock high, overflow, busy) → no credit, coin_reject pulses once. The events are consumed.
- Same-cycle ordering: credit is resolved first, then charge against the post-credit balance, then refund_req.
- Charge (IDLE only): charge_amt ≤ balance → subtract, charge_ack. Otherwise, or when busy → balance unchanged, charge_nak. charge_amt = 0 always acks.
- FSM states are IDLE, DISPENSE and GAP.
  - IDLE → DISPENSE on refund_req; busy rises.
  - DISPENSE: select the highest i with COIN_VALUES[i] ≤ balance, pulse disp_coin[i] for one cycle, subtract the value, go to GAP.
  - DISPENSE when no coin fits: refund_lost ← balance, balance ← 0, → IDLE, busy falls.
  - GAP counts GAP_CYCLES, then returns to DISPENSE.
- refund_req while busy is ignored. refund_lost holds its value until the next refund completes.
- All arithmetic is WIDTH-bit unsigned. Overflow is prevented by the MAX_BALANCE check and underflow by the charge compare.

## Timing
- Reset values: balance 0, refund_lost 0, disp_coin 0, charge_ack/charge_nak/coin_reject 0, busy 0, FSM in IDLE, all synchroniser and last-value flops 0.
- Mid-operation rst aborts a dispense immediately. Pulses already emitted stand; the remaining balance is cleared without setting refund_lost.
- Credit latency, with coin_in first sampled high at edge n:
  - with the synchroniser, balance updates at edge n+2;
  - without it, balance updates at edge n.
- coin_reject follows the same latency.
- Charge: charge_valid sampled at edge n → balance and ack/nak registered at edge n, visible for the one following cycle.
- Dispense cadence: busy rises at edge n (refund_req sampled). The first disp_coin is at edge n+1, then one pulse every GAP_CYCLES+1 cycles.

## Configuration
- COIN_ACCUMULATOR_SYNC_EN defined: the 2-flop synchroniser is instantiated per channel; 2 extra cycles of credit latency.
- Undefined: edge detection runs directly on coin_in. This is for bench use or when coin_in is already synchronous.

## Structure
- Package coin_accumulator_pkg holds:
  - FSM state typedef/encodings (IDLE, DISPENSE, GAP);
  - default denomination constants COIN_HALF_1 = 2 and COIN_HALF_10 = 20;
  - default WIDTH and MAX_BALANCE.
- Sub-module coin_edge_detect: one channel of optional synchroniser plus rising-edge detector, with a one-cycle event output. Instantiated NUM_COINS times via generate.

## Test plan
- Defaults, sync on: coin_in[0] high for 5 cycles from edge n → balance 2 at edge n+2, credited once only; coin_reject stays 0.
- coin_in[0] and coin_in[1] rise in the same cycle → balance unchanged, one coin_reject pulse. Repeat with lock=1 and a single coin → same result.
- Balance 240, coin_in[1] event → coin_reject, balance stays 240. Balance 230, coin_in[1] → balance 250.
- Balance 22:
  - charge_amt 20 → charge_ack, balance 2;
  - then charge_amt 5 → charge_nak, balance 2;
  - charge same cycle as a coin_in[1] credit with amt 21 → ack, balance 1.
- Balance 43, refund_req → disp_coin 10, 10, 01, each 3 cycles apart (GAP_CYCLES=2). Then refund_lost 1, balance 0, busy low. A coin event and a charge during busy → reject and nak.
- rst asserted in GAP after the first pulse → next cycle: IDLE, balance 0, busy 0, disp_coin 0, refund_lost 0.
